// File: rtl/fp8_accum_seq_if.sv
// fp8_accum_seq_if: operand stream, result stream and adder drive bundle.
// slave = accumulator side, master = producer/consumer/adder side.
//   in_*   : operand stream {data, funct, last} with valid/ready
//   add_*  : drive to and result from the external 8-bit float adder
//   out_*  : one result per group {data, zero, count} with valid/ready
//   busy   : accumulator has work in flight
interface fp8_accum_seq_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_funct;
    logic             in_last;

    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_funct;
    logic [7:0]       add_y;
    logic             add_zero;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;

    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_funct,
        input  in_last,
        input  add_y,
        input  add_zero,
        input  out_ready,
        output in_ready,
        output add_a,
        output add_b,
        output add_funct,
        output out_valid,
        output out_data,
        output out_zero,
        output out_count,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_funct,
        output in_last,
        output add_y,
        output add_zero,
        output out_ready,
        input  in_ready,
        input  add_a,
        input  add_b,
        input  add_funct,
        input  out_valid,
        input  out_data,
        input  out_zero,
        input  out_count,
        input  busy
    );
endinterface

// File: rtl/fp8_accum_seq.sv
// fp8_accum_seq: buffers fp8 terms and accumulates each group through
// an external combinational adder, one result per group.
// Ports: clk, rst_n (async, active-low), bus (fp8_accum_seq_if.slave):
//   in_*  operand FIFO input, add_* adder drive/capture,
//   out_* group result handshake, busy = work pending.
module fp8_accum_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fp8_accum_seq_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        EXEC     = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [9:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [9:0]       head;

    logic [7:0]       acc;
    logic [7:0]       op_reg;
    logic             op_funct;
    logic             op_last;
    logic             zero_r;
    logic             first;
    logic [CNT_W-1:0] count;

    logic             do_exec;
    logic             do_clear;

    // Extra pointer bit separates full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign push  = bus.in_valid && !full;
    assign pop   = (state == LOAD) && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: empty pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {bus.in_last, bus.in_funct, bus.in_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        do_exec  = 1'b0;
        do_clear = 1'b0;
        unique case (state)
            LOAD: begin
                if (!empty) state_nx = EXEC;
            end
            EXEC: begin
                do_exec  = 1'b1;
                state_nx = op_last ? WAIT_OUT : LOAD;
            end
            WAIT_OUT: begin
                if (bus.out_ready) begin
                    do_clear = 1'b1;
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg   <= 8'h00;
            op_funct <= 1'b0;
            op_last  <= 1'b0;
        end else if (pop) begin
            {op_last, op_funct, op_reg} <= head;
        end
    end

    // The first term of a group bypasses the adder: a subtracted
    // first term only needs its sign flipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 8'h00;
            zero_r <= 1'b0;
            count  <= '0;
            first  <= 1'b1;
        end else if (do_exec) begin
            if (first) begin
                acc    <= op_funct ? {~op_reg[7], op_reg[6:0]} : op_reg;
                zero_r <= (op_reg[6:0] == 7'd0);
            end else begin
                acc    <= bus.add_y;
                zero_r <= bus.add_zero;
            end
            count <= (count == CNT_MAX) ? count : count + 1'b1;
            first <= 1'b0;
        end else if (do_clear) begin
            acc    <= 8'h00;
            zero_r <= 1'b0;
            count  <= '0;
            first  <= 1'b1;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.add_a     = acc;
    assign bus.add_b     = op_reg;
    assign bus.add_funct = op_funct;
    assign bus.out_valid = (state == WAIT_OUT);
    assign bus.out_data  = acc;
    assign bus.out_zero  = zero_r;
    assign bus.out_count = count;
    assign bus.busy      = (state != LOAD) || !empty;

endmodule
